// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control, branch-operand and status bundle between the datapath and pc_unit
interface pc_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic             stall;
  logic [2:0]       br_op;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [15:0]      imm16;
  logic             j;
  logic             jal;
  logic             jr;
  logic [25:0]      instr_index;
  logic [WIDTH-1:0] gpr_rs;
  logic             exc_req;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] jal_out;
  logic             redirect;
  logic             pend_valid;
  logic             misalign;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output stall, br_op, cmp_a, cmp_b, imm16, j, jal, jr, instr_index, gpr_rs, exc_req, eret,
    input  pc, jal_out, redirect, pend_valid, misalign, retire_cnt, taken_cnt
  );

  modport slave (
    input  stall, br_op, cmp_a, cmp_b, imm16, j, jal, jr, instr_index, gpr_rs, exc_req, eret,
    output pc, jal_out, redirect, pend_valid, misalign, retire_cnt, taken_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered program counter with branch/jump selection, stall capture and counters (optional PC_EXC_EN)
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter int               PC_STEP    = 4,
  parameter int               CNT_W      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180
) (
  input logic     clk,
  input logic     reset,
  pc_unit_if.slave bus
);

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  // RUN: follow the selected target; HOLD: a redirect captured under stall is waiting
  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  logic [WIDTH-1:0] seq, br_tgt, j_tgt, target;
  logic             br_taken, redirect, exc_take;
  logic             a_neg, a_zero;

`ifdef PC_EXC_EN
  logic [WIDTH-1:0] epc_q, epc_d;
`else
  logic             unused_exc;
  assign unused_exc = bus.exc_req ^ bus.eret;
`endif

  assign seq    = pc_q + WIDTH'(PC_STEP);
  assign br_tgt = seq + {{(WIDTH-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign j_tgt  = {seq[WIDTH-1:28], bus.instr_index, 2'b00};
  assign a_neg  = bus.cmp_a[WIDTH-1];
  assign a_zero = (bus.cmp_a == '0);

  // state register and all datapath flops; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      retire_q      <= '0;
      taken_q       <= '0;
`ifdef PC_EXC_EN
      epc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      retire_q      <= retire_d;
      taken_q       <= taken_d;
`ifdef PC_EXC_EN
      epc_q         <= epc_d;
`endif
    end
  end

  // output logic: branch resolution and prioritised target selection for this cycle
  always_comb begin
    br_taken = 1'b0;
    case (bus.br_op)
      BR_BEQ:  br_taken = (bus.cmp_a == bus.cmp_b);
      BR_BNE:  br_taken = (bus.cmp_a != bus.cmp_b);
      BR_BLEZ: br_taken = a_neg | a_zero;
      BR_BGTZ: br_taken = ~a_neg & ~a_zero;
      BR_BLTZ: br_taken = a_neg;
      BR_BGEZ: br_taken = ~a_neg;
      default: br_taken = 1'b0;
    endcase
    target   = seq;
    redirect = 1'b1;
`ifdef PC_EXC_EN
    if (bus.eret)                 target = epc_q;
    else
`endif
    if (bus.jr)                   target = bus.gpr_rs;
    else if (bus.j || bus.jal)    target = j_tgt;
    else if (br_taken)            target = br_tgt;
    else                          redirect = 1'b0;
`ifdef PC_EXC_EN
    // a misaligned pc traps on the edge after it appears, just like an external request
    exc_take = bus.exc_req | (pc_q[1:0] != 2'b00);
`else
    exc_take = 1'b0;
`endif
  end

  // next-state logic: exception, HOLD release, RUN advance or capture under stall
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    retire_d      = retire_q;
    taken_d       = taken_q;
`ifdef PC_EXC_EN
    epc_d         = epc_q;
`endif
    if (!bus.stall) retire_d = retire_q + CNT_W'(1);
    if (exc_take) begin
`ifdef PC_EXC_EN
      epc_d = pc_q;
`endif
      pc_d    = EXC_VECTOR;
      state_d = ST_RUN;
      taken_d = taken_q + CNT_W'(1);
    end else if (state_q == ST_HOLD) begin
      // first captured redirect wins; live controls are ignored on release
      if (!bus.stall) begin
        pc_d    = pend_target_q;
        state_d = ST_RUN;
        taken_d = taken_q + CNT_W'(1);
      end
    end else if (!bus.stall) begin
      pc_d = target;
      if (redirect) taken_d = taken_q + CNT_W'(1);
    end else if (redirect) begin
      pend_target_d = target;
      state_d       = ST_HOLD;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.jal_out    = seq;
  assign bus.redirect   = redirect;
  assign bus.pend_valid = (state_q == ST_HOLD);
  assign bus.misalign   = (pc_q[1:0] != 2'b00);
  assign bus.retire_cnt = retire_q;
  assign bus.taken_cnt  = taken_q;

endmodule
